// File: rtl/router_sw_alloc_pkg.sv
// router_sw_alloc_pkg
// Shared definitions for the router switch-allocation stage:
//   - port index constants (Local, North, East, South, West)
//   - flit field positions and widths
//   - per-input FSM state encoding
//   - XY route function mapping a flit's destination to an output port index
package router_sw_alloc_pkg;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  // Flit layout: [7:6] dest X, [5:4] dest Y, [3:0] payload.
  localparam int FLIT_W    = 8;
  localparam int COORD_W   = 2;
  localparam int PAYLOAD_W = 4;
  localparam int DX_LSB    = 6;
  localparam int DY_LSB    = 4;

  // Occupancy counter width; holds 0..DEPTH for DEPTH up to 15.
  localparam int OCC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing in flight; pop the FIFO when it has data
    ST_WAIT = 2'b01,  // FIFO data_out is valid this cycle; capture it
    ST_HELD = 2'b10   // head flit held, requesting its routed output
  } in_state_e;

  // Dimension-ordered XY routing: resolve X first, then Y, else eject locally.
  function automatic logic [2:0] route(input logic [FLIT_W-1:0]  flit,
                                       input logic [COORD_W-1:0] my_x,
                                       input logic [COORD_W-1:0] my_y);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = flit[DX_LSB +: COORD_W];
    dy = flit[DY_LSB +: COORD_W];
    if (dx > my_x)      route = P_EAST;
    else if (dx < my_x) route = P_WEST;
    else if (dy > my_y) route = P_NORTH;
    else if (dy < my_y) route = P_SOUTH;
    else                route = P_LOCAL;
  endfunction

endpackage

// File: rtl/router_sw_alloc_if.sv
// router_sw_alloc_if
// Bundles the FIFO-side and output-side signals of the switch allocator.
//   wr_in      : copy of each input FIFO's write strobe
//   fifo_data  : each input FIFO's data_out, port i at [8i+7:8i]
//   rd_out     : read strobe to each input FIFO
//   out_ready  : downstream of output p can accept a flit this cycle
//   out_data   : registered output flit per output port
//   out_valid  : one-cycle write strobe per forwarded flit
// slave modport is the allocator's view; master is the surrounding fabric.
interface router_sw_alloc_if #(
  parameter int NPORTS = 5
) ();

  logic [NPORTS-1:0]   wr_in;
  logic [8*NPORTS-1:0] fifo_data;
  logic [NPORTS-1:0]   rd_out;
  logic [NPORTS-1:0]   out_ready;
  logic [8*NPORTS-1:0] out_data;
  logic [NPORTS-1:0]   out_valid;

  modport slave (
    input  wr_in, fifo_data, out_ready,
    output rd_out, out_data, out_valid
  );

  modport master (
    output wr_in, fifo_data, out_ready,
    input  rd_out, out_data, out_valid
  );

endinterface

// File: rtl/router_sw_alloc_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter for one output port.
//   clk, rst : clock, asynchronous active-high reset
//   en       : output can accept a flit this cycle; no grant when low
//   req      : one request bit per input
//   gnt      : one-hot grant (all zero when nothing is granted)
// The scan starts at the internal pointer; after a grant the pointer moves to
// the input just past the winner so that input gets lowest priority next time.
module rr_arbiter #(
  parameter int NPORTS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] gnt
);

  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] winner;
  logic             found;
  int               idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = PTR_W'(idx);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (int'(winner) == NPORTS - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/router_sw_alloc.sv
// router_sw_alloc
// Switch-allocation stage of the mesh router. Pops head flits from the five
// input FIFOs, XY-routes each one, arbitrates every output round-robin and
// registers the winners onto per-output data/valid lines.
//   clk, rst : clock, asynchronous active-high reset (FIFOs share this reset)
//   bus      : router_sw_alloc_if.slave (wr_in, fifo_data, out_ready in;
//              rd_out, out_data, out_valid out)
// The FIFOs expose no flags, so occupancy is mirrored from their write
// strobes and our own read strobes.
module router_sw_alloc
  import router_sw_alloc_pkg::*;
#(
  parameter int         NPORTS = 5,
  parameter int         DEPTH  = 8,
  parameter logic [1:0] MY_X   = 2'd0,
  parameter logic [1:0] MY_Y   = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  router_sw_alloc_if.slave bus
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  in_state_e                     state_q [NPORTS];
  in_state_e                     state_d [NPORTS];
  logic [OCC_W-1:0]              occ_q   [NPORTS];
  logic [FLIT_W-1:0]             head_q  [NPORTS];

  // req[p][i] / gnt[p][i]: input i requests / wins output p.
  logic [NPORTS-1:0][NPORTS-1:0] req;
  logic [NPORTS-1:0][NPORTS-1:0] gnt;
  logic [NPORTS-1:0]             granted;
  logic [NPORTS-1:0]             rd;
  logic [FLIT_W-1:0]             win_data   [NPORTS];
  logic [FLIT_W-1:0]             out_data_q [NPORTS];
  logic [NPORTS-1:0]             out_valid_q;

  // Each held input requests exactly one output, so an input can never be
  // granted by two arbiters in the same cycle.
  always_comb begin
    req = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (state_q[i] == ST_HELD) req[route(head_q[i], MY_X, MY_Y)][i] = 1'b1;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_out
    rr_arbiter #(.NPORTS(NPORTS)) u_arb (
      .clk (clk),
      .rst (rst),
      .en  (bus.out_ready[p]),
      .req (req[p]),
      .gnt (gnt[p])
    );

    assign bus.out_data[8*p +: 8] = out_data_q[p];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.rd_out    = rd;

  // Collapse the per-output one-hot grants into a per-input "granted" flag
  // and a per-output winning flit.
  always_comb begin
    granted = '0;
    for (int p = 0; p < NPORTS; p++) begin
      win_data[p] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt[p][i]) begin
          granted[i]  = 1'b1;
          win_data[p] = head_q[i];
        end
      end
    end
  end

  // Input FSMs. A granted input with more flits queued pops the next one in
  // the same cycle, giving one flit per two cycles per input.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      state_d[i] = state_q[i];
      rd[i]      = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (occ_q[i] != '0) begin
            rd[i]      = 1'b1;
            state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: state_d[i] = ST_HELD;
        ST_HELD: begin
          if (granted[i]) begin
            if (occ_q[i] != '0) begin
              rd[i]      = 1'b1;
              state_d[i] = ST_WAIT;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // NOTE: the head registers are reset like any other state so a flit held
  // before reset can never resurface afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i] <= ST_IDLE;
        occ_q[i]   <= '0;
        head_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i] <= state_d[i];
        if (state_q[i] == ST_WAIT) head_q[i] <= bus.fifo_data[8*i +: 8];
        // A write into a full FIFO is dropped; a simultaneous write and
        // read leave the count unchanged.
        case ({bus.wr_in[i], rd[i]})
          2'b10:   if (occ_q[i] < OCC_MAX) occ_q[i] <= occ_q[i] + 1'b1;
          2'b01:   if (occ_q[i] != '0)     occ_q[i] <= occ_q[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Output registers: out_valid pulses for one cycle per grant, out_data
  // keeps its last flit between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      for (int p = 0; p < NPORTS; p++) out_data_q[p] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        out_valid_q[p] <= |gnt[p];
        if (|gnt[p]) out_data_q[p] <= win_data[p];
      end
    end
  end

endmodule

// File: tb/tb_router_sw_alloc.sv
// tb_router_sw_alloc
// Self-checking bench for router_sw_alloc (MY_X=1, MY_Y=1). A queue model of
// the five input FIFOs feeds the DUT; a per-input scoreboard of accepted
// flits checks every emitted flit for order, route and out_ready legality.
// Directed steps check exact latencies, arbitration order, back-pressure,
// saturation, simultaneous read/write and reset; a random phase follows.
module tb_router_sw_alloc;

  localparam int         NP    = 5;
  localparam int         DEPTH = 8;
  localparam logic [1:0] MY_X  = 2'd1;
  localparam logic [1:0] MY_Y  = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_sw_alloc_if #(.NPORTS(NP)) bus ();

  router_sw_alloc #(
    .NPORTS (NP),
    .DEPTH  (DEPTH),
    .MY_X   (MY_X),
    .MY_Y   (MY_Y)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          total_emit = 0;
  logic [7:0]  fifo_q   [NP][$];  // contents of each input FIFO
  logic [7:0]  exp_q    [NP][$];  // accepted, not yet emitted, per input
  logic [7:0]  emit_log [NP][$];  // emitted flits per output
  logic [7:0]  wr_data  [NP];
  logic [NP-1:0] s_rd, s_ov, prev_ready;
  logic [7:0]  s_od [NP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY routing written straight from the routing rule.
  function automatic int ref_route(input logic [7:0] f);
    int dx, dy;
    dx = int'(f[7:6]);
    dy = int'(f[5:4]);
    if (dx > int'(MY_X)) return 2;
    if (dx < int'(MY_X)) return 4;
    if (dy > int'(MY_Y)) return 1;
    if (dy < int'(MY_Y)) return 3;
    return 0;
  endfunction

  function automatic logic model_empty();
    for (int i = 0; i < NP; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic score(input int p, input logic [7:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (!found && exp_q[i].size() != 0 && exp_q[i][0] == d) begin
        void'(exp_q[i].pop_front());
        found = 1'b1;
      end
    end
    check($sformatf("emit_known_p%0d_%02h", p, d), 32'(found), 32'd1);
    check($sformatf("emit_route_p%0d_%02h", p, d), 32'(ref_route(d)), 32'(p));
    check($sformatf("emit_ready_p%0d", p), 32'(prev_ready[p]), 32'd1);
    emit_log[p].push_back(d);
    total_emit++;
  endtask

  // One clock cycle. Called right after a falling edge with inputs set;
  // samples outputs, scores emissions, then updates the FIFO model after
  // the rising edge and returns at the next falling edge.
  task automatic tick();
    logic [NP-1:0] rd_now, wr_now;
    logic acc;
    #1;
    rd_now = bus.rd_out;
    wr_now = bus.wr_in;
    s_rd   = rd_now;
    s_ov   = bus.out_valid;
    for (int p = 0; p < NP; p++) begin
      s_od[p] = bus.out_data[8*p +: 8];
      if (s_ov[p]) score(p, s_od[p]);
    end
    for (int i = 0; i < NP; i++)
      if (rd_now[i]) check($sformatf("rd_nonempty_%0d", i), 32'(fifo_q[i].size() != 0), 32'd1);
    prev_ready = bus.out_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      acc = wr_now[i] && ((fifo_q[i].size() < DEPTH) || rd_now[i]);
      if (rd_now[i] && fifo_q[i].size() != 0) bus.fifo_data[8*i +: 8] = fifo_q[i].pop_front();
      if (acc) begin
        fifo_q[i].push_back(wr_data[i]);
        exp_q[i].push_back(wr_data[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_wr(input int i, input logic [7:0] d);
    bus.wr_in[i] = 1'b1;
    wr_data[i]   = d;
  endtask

  task automatic clear_wr();
    bus.wr_in = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < NP; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
    end
    bus.wr_in     = '0;
    bus.fifo_data = '0;
    prev_ready    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single uncontended flit 8'h9A from Local: read at cycle 1, out at cycle 4 East.
  task automatic latency_9a();
    push_wr(0, 8'h9A); tick();                         // cycle 0
    clear_wr();        tick();                         // cycle 1
    check("lat_c1_rd", 32'(s_rd), 32'h01);
    tick();                                            // cycle 2
    check("lat_c2_rd", 32'(s_rd), 32'h00);
    tick();                                            // cycle 3
    check("lat_c3_ov", 32'(s_ov), 32'h00);
    tick();                                            // cycle 4
    check("lat_c4_ov", 32'(s_ov), 32'h04);
    check("lat_c4_data", 32'(s_od[2]), 32'h9A);
    tick();                                            // cycle 5
    check("lat_c5_ov", 32'(s_ov), 32'h00);
    check("lat_c5_hold", 32'(s_od[2]), 32'h9A);
  endtask

  initial begin
    logic [7:0] f;
    logic [NP-1:0] seq;
    int base;

    bus.wr_in = '0; bus.fifo_data = '0; bus.out_ready = '0;
    prev_ready = '0; seq = '0;
    for (int i = 0; i < NP; i++) wr_data[i] = '0;
    @(negedge clk);
    apply_reset();
    #1;
    for (int p = 0; p < NP; p++) check($sformatf("rst_out_data_%0d", p), 32'(bus.out_data[8*p +: 8]), 32'd0);
    @(negedge clk);

    // --- latency ---------------------------------------------------------
    bus.out_ready = '1;
    latency_9a();

    // --- round robin on Local output: port 1 then port 3, rr[0] -> 4 ---
    push_wr(1, 8'h55); push_wr(3, 8'h5C); tick();      // cycle 0
    clear_wr(); tick(); tick(); tick();                // cycles 1..3
    tick();
    check("rr_c4_ov", 32'(s_ov[0]), 32'd1);
    check("rr_c4_data", 32'(s_od[0]), 32'h55);
    tick();
    check("rr_c5_ov", 32'(s_ov[0]), 32'd1);
    check("rr_c5_data", 32'(s_od[0]), 32'h5C);
    tick();
    check("rr_c6_ov", 32'(s_ov[0]), 32'd0);
    // With rr[0]=4, port 4 must now beat port 0.
    push_wr(0, 8'h51); push_wr(4, 8'h5E); tick();
    clear_wr(); tick(); tick(); tick();
    tick();
    check("rr2_c4_data", 32'(s_od[0]), 32'h5E);
    tick();
    check("rr2_c5_data", 32'(s_od[0]), 32'h51);
    tick();

    // --- back-pressure on West output ------------------------------------
    bus.out_ready = 5'b01111;
    push_wr(2, 8'h17); tick();                         // cycle 0
    clear_wr();
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("bp_c%0d_ov4", c), 32'(s_ov[4]), 32'd0);
      if (c >= 2) check($sformatf("bp_c%0d_rd2", c), 32'(s_rd[2]), 32'd0);
    end
    bus.out_ready = '1;
    tick();                                            // cycle 13: grant
    check("bp_grant_rd2", 32'(s_rd[2]), 32'd0);
    tick();                                            // cycle 14
    check("bp_release_ov4", 32'(s_ov[4]), 32'd1);
    check("bp_release_data", 32'(s_od[4]), 32'h17);
    tick();

    // --- saturation: ten writes, no drain. One flit goes to the head
    // register, eight fill the FIFO, the tenth is dropped. ---------------
    bus.out_ready = '0;
    for (int k = 0; k < 10; k++) begin
      f = {4'($urandom_range(15)), 4'(k)};
      push_wr(2, f);
      tick();
    end
    clear_wr(); tick(); tick();
    check("sat_hold_rd", 32'(s_rd), 32'd0);
    base = total_emit;
    bus.out_ready = '1;
    for (int n = 0; n < 100 && !model_empty(); n++) tick();
    check("sat_drained", 32'(model_empty()), 32'd1);
    check("sat_count", 32'(total_emit - base), 32'd9);
    tick(); tick();

    // --- simultaneous write and read at occ=3, five-flit stream North ----
    emit_log[1].delete();
    bus.out_ready = 5'b11101;
    for (int k = 0; k < 4; k++) begin
      push_wr(1, 8'h60 + 8'(k));
      tick();                                          // cycles 0..3
    end
    bus.out_ready = '1;
    push_wr(1, 8'h64);
    tick();                                            // cycle 4: wr + rd
    check("rw_same_rd1", 32'(s_rd[1]), 32'd1);
    clear_wr();
    for (int n = 0; n < 60 && !model_empty(); n++) tick();
    check("rw_drained", 32'(model_empty()), 32'd1);
    check("rw_count", 32'(emit_log[1].size()), 32'd5);
    for (int k = 0; k < 5 && k < emit_log[1].size(); k++)
      check($sformatf("rw_order_%0d", k), 32'(emit_log[1][k]), 32'h60 + 32'(k));

    // --- reset with flits in WAIT/HELD -----------------------------------
    bus.out_ready = '1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NP; i++) push_wr(i, 8'($urandom_range(255)));
      tick();
    end
    clear_wr();
    tick();                                            // cycle 3: grants
    apply_reset();                                     // lands in cycle 4
    base = total_emit;
    for (int c = 0; c < 15; c++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", c), 32'({s_ov, s_rd}), 32'd0);
    end
    check("post_rst_no_emit", 32'(total_emit - base), 32'd0);
    latency_9a();

    // --- random traffic --------------------------------------------------
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(2) == 0) begin
          seq[i] = ~seq[i];
          push_wr(i, {4'($urandom_range(15)), 3'(i), seq[i]});
        end else begin
          bus.wr_in[i] = 1'b0;
        end
        bus.out_ready[i] = ($urandom_range(3) != 0);
      end
      tick();
    end
    clear_wr();
    bus.out_ready = '1;
    for (int n = 0; n < 200 && !model_empty(); n++) tick();
    check("rand_drained", 32'(model_empty()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
